// File: rtl/sdp_y_chn_pkg.sv
// Shared constants and types for the SDP Y-core input-channel skid buffer.
package sdp_y_chn_pkg;

    localparam int SDP_CHN_PD_W       = 128;
    localparam int SDP_CHN_SKID_DEPTH = 2;

    typedef logic [SDP_CHN_PD_W-1:0] chn_pd_t;

    // Pointer width for a DEPTH-entry array; a single entry still needs one bit.
    function automatic int chn_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdp_y_chn_in_skid_dp_chk.sv
// Occupancy bound checker for sdp_y_chn_in_skid_dp; only built with SDP_CHN_IN_OCC_EN.
`ifdef SDP_CHN_IN_OCC_EN
module sdp_y_chn_in_skid_dp_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic             nvdla_core_clk,
    input logic             nvdla_core_rstn,
    input logic [CNT_W-1:0] count
);

    a_count_le_depth: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        count <= CNT_W'(DEPTH));

endmodule
`endif

// File: rtl/sdp_y_chn_skid_mem.sv
// DEPTH x WIDTH flop storage for the skid buffer: one write port, one combinational read port.
module sdp_y_chn_skid_mem
    import sdp_y_chn_pkg::*;
#(
    parameter int WIDTH = SDP_CHN_PD_W,
    parameter int DEPTH = SDP_CHN_SKID_DEPTH,
    parameter int AW    = chn_ptr_w(DEPTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: cleared on reset so no stale payload survives it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sdp_y_chn_in_skid_dp.sv
// Input-channel skid buffer with zero-latency bypass when empty and registered input ready.
// Optional macro SDP_CHN_IN_OCC_EN adds the chn_occ occupancy output.
module sdp_y_chn_in_skid_dp
    import sdp_y_chn_pkg::*;
#(
    parameter  int WIDTH = SDP_CHN_PD_W,
    parameter  int DEPTH = SDP_CHN_SKID_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = chn_ptr_w(DEPTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             chn_in_vld,
    output logic             chn_in_rdy,
    input  logic [WIDTH-1:0] chn_in_pd,
    output logic             chn_out_vld,
    input  logic             chn_out_rdy,
    output logic [WIDTH-1:0] chn_out_pd
`ifdef SDP_CHN_IN_OCC_EN
    ,
    output logic [CNT_W-1:0] chn_occ
`endif
);

    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic             rdy_r;

    logic             empty_s;
    logic             acc_s;
    logic             take_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [WIDTH-1:0] head_pd_s;

    // Handshake decode: a word accepted while empty and consumed at once bypasses storage.
    always_comb begin
        empty_s = (count_r == CNT_W'(0));
        acc_s   = chn_in_vld & rdy_r;
        take_s  = chn_out_vld & chn_out_rdy;
        push_s  = acc_s & ~(empty_s & chn_out_rdy);
        pop_s   = take_s & ~empty_s;
    end

    // Next-state for occupancy and the wrapping pointers.
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = (rd_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // State registers; ready is precomputed from next occupancy so it never sees chn_out_rdy combinationally.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            count_r  <= CNT_W'(0);
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            rdy_r    <= 1'b1;
        end else begin
            count_r  <= count_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rdy_r    <= (count_nxt_s != CNT_W'(DEPTH));
        end
    end

    sdp_y_chn_skid_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .we              (push_s),
        .waddr           (wr_ptr_r),
        .wdata           (chn_in_pd),
        .raddr           (rd_ptr_r),
        .rdata           (head_pd_s)
    );

    assign chn_in_rdy  = rdy_r;
    assign chn_out_vld = ~empty_s | chn_in_vld;
    assign chn_out_pd  = empty_s ? chn_in_pd : head_pd_s;

`ifdef SDP_CHN_IN_OCC_EN
    assign chn_occ = count_r;

    sdp_y_chn_in_skid_dp_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .count           (count_r)
    );
`endif

endmodule

// File: tb/tb_sdp_y_chn_in_skid_dp.sv
// Bench for sdp_y_chn_in_skid_dp: DEPTH=2 and DEPTH=3 instances against a queue model.
// Honours SDP_CHN_IN_OCC_EN by also checking chn_occ.
module tb_sdp_y_chn_in_skid_dp;

    logic         clk = 1'b0;
    logic         rstn;
    logic         vld;
    logic         ordy;
    logic [127:0] pd;

    logic         rdy2, ovld2, rdy3, ovld3;
    logic [127:0] opd2, opd3;
`ifdef SDP_CHN_IN_OCC_EN
    logic [1:0]   occ2, occ3;
`endif

    int tests = 0;
    int fails = 0;

    // Model: per instance, the ordered list of words held inside the buffer.
    logic [127:0] mq [2][$];

    always #5 clk = ~clk;

    sdp_y_chn_in_skid_dp #(.WIDTH(128), .DEPTH(2)) u_dut2 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .chn_in_vld      (vld),
        .chn_in_rdy      (rdy2),
        .chn_in_pd       (pd),
        .chn_out_vld     (ovld2),
        .chn_out_rdy     (ordy),
        .chn_out_pd      (opd2)
`ifdef SDP_CHN_IN_OCC_EN
        ,
        .chn_occ         (occ2)
`endif
    );

    sdp_y_chn_in_skid_dp #(.WIDTH(128), .DEPTH(3)) u_dut3 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .chn_in_vld      (vld),
        .chn_in_rdy      (rdy3),
        .chn_in_pd       (pd),
        .chn_out_vld     (ovld3),
        .chn_out_rdy     (ordy),
        .chn_out_pd      (opd3)
`ifdef SDP_CHN_IN_OCC_EN
        ,
        .chn_occ         (occ3)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare one instance against its queue, then advance the queue over the coming edge.
    task automatic model_step(input int k, input int depth, input logic ovld,
                              input logic [127:0] opd, input logic irdy);
        logic was_empty;
        logic exp_vld;
        logic exp_rdy;
        was_empty = (mq[k].size() == 0);
        exp_vld   = !was_empty || vld;
        exp_rdy   = (mq[k].size() < depth);
        chk($sformatf("in_rdy_d%0d", depth), {127'd0, irdy}, {127'd0, exp_rdy});
        chk($sformatf("out_vld_d%0d", depth), {127'd0, ovld}, {127'd0, exp_vld});
        if (exp_vld) begin
            chk($sformatf("out_pd_d%0d", depth), opd, was_empty ? pd : mq[k][0]);
        end
        if (exp_vld && ordy && !was_empty) begin
            void'(mq[k].pop_front());
        end
        if (vld && exp_rdy && !(was_empty && ordy)) begin
            mq[k].push_back(pd);
        end
    endtask

    task automatic model_all();
`ifdef SDP_CHN_IN_OCC_EN
        chk("occ_d2", {126'd0, occ2}, 128'(mq[0].size()));
        chk("occ_d3", {126'd0, occ3}, 128'(mq[1].size()));
`endif
        model_step(0, 2, ovld2, opd2, rdy2);
        model_step(1, 3, ovld3, opd3, rdy3);
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic cyc(input logic v, input logic [127:0] p, input logic r);
        @(posedge clk);
        #1;
        vld  = v;
        pd   = p;
        ordy = r;
        @(negedge clk);
        model_all();
    endtask

    initial begin
        logic [127:0] a5;
        logic         bv;
        logic         br;
        a5   = {16{8'hA5}};
        rstn = 1'b0;
        vld  = 1'b0;
        ordy = 1'b0;
        pd   = 128'd0;
        #12;
        chk("rst_rdy2", {127'd0, rdy2}, 128'd1);
        chk("rst_vld2", {127'd0, ovld2}, 128'd0);
        chk("rst_rdy3", {127'd0, rdy3}, 128'd1);
        chk("rst_vld3", {127'd0, ovld3}, 128'd0);
        rstn = 1'b1;

        // Bypass when empty
        cyc(1'b1, a5, 1'b1);
        chk("byp_vld", {127'd0, ovld2}, 128'd1);
        chk("byp_pd", opd2, a5);
        chk("byp_model_empty", 128'(mq[0].size()), 128'd0);

        // Fill DEPTH=2, hold off 0x3, then full+pop in the same cycle
        cyc(1'b1, 128'h1, 1'b0);
        cyc(1'b1, 128'h2, 1'b0);
        chk("fill_model_cnt", 128'(mq[0].size()), 128'd2);
        cyc(1'b1, 128'h3, 1'b0);
        chk("full_rdy", {127'd0, rdy2}, 128'd0);
        cyc(1'b1, 128'h3, 1'b1);
        chk("full_pop_rdy", {127'd0, rdy2}, 128'd0);
        chk("out_1", opd2, 128'h1);
        cyc(1'b1, 128'h3, 1'b1);
        chk("rdy_back", {127'd0, rdy2}, 128'd1);
        chk("out_2", opd2, 128'h2);
        cyc(1'b0, 128'h0, 1'b1);
        chk("out_3", opd2, 128'h3);
        chk("out_3_vld", {127'd0, ovld2}, 128'd1);
        cyc(1'b0, 128'h0, 1'b1);
        chk("drained_vld2", {127'd0, ovld2}, 128'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 128'h0, 1'b1);

        // Steady push+pop on a non-empty DEPTH=3 buffer: pointers wrap, count constant
        cyc(1'b1, 128'h10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 128'(32'h11 + i), 1'b1);
            chk("wrap_pd", opd3, 128'(32'h10 + i));
            chk("wrap_rdy", {127'd0, rdy3}, 128'd1);
            chk("wrap_cnt", 128'(mq[1].size()), 128'd1);
        end
        cyc(1'b0, 128'h0, 1'b1);
        chk("wrap_last", opd3, 128'h1A);

        // Reset with two words buffered
        cyc(1'b1, 128'h51, 1'b0);
        cyc(1'b1, 128'h52, 1'b0);
        @(posedge clk);
        #2;
        vld  = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mrst_vld2", {127'd0, ovld2}, 128'd0);
        chk("mrst_rdy2", {127'd0, rdy2}, 128'd1);
        chk("mrst_vld3", {127'd0, ovld3}, 128'd0);
        chk("mrst_rdy3", {127'd0, rdy3}, 128'd1);
        mq[0].delete();
        mq[1].delete();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 128'h0, 1'b1);
        cyc(1'b1, 128'h60, 1'b1);
        chk("post_rst_byp", opd2, 128'h60);

        // Random traffic with drifting bias between producer and consumer
        for (int i = 0; i < 10000; i++) begin
            case ((i / 500) % 4)
                0:       begin bv = ($urandom_range(0, 3) != 0); br = ($urandom_range(0, 3) == 0); end
                1:       begin bv = ($urandom_range(0, 3) == 0); br = ($urandom_range(0, 3) != 0); end
                default: begin bv = $urandom_range(0, 1) == 1;   br = $urandom_range(0, 1) == 1;   end
            endcase
            cyc(bv, {$urandom, $urandom, $urandom, $urandom}, br);
            if (mq[0].size() > 2 || mq[1].size() > 3) begin
                chk("model_bound", 128'(mq[0].size() + mq[1].size()), 128'd5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
